// File: rtl/predictor_pkg.sv
// Shared types for the gshare predictor: 2-bit counter encoding, controller FSM states
// and the saturating counter update helpers.
package predictor_pkg;

    typedef logic [1:0] counter_t;

    localparam counter_t SNT = 2'b00;
    localparam counter_t WNT = 2'b01;
    localparam counter_t WT  = 2'b10;
    localparam counter_t ST  = 2'b11;

    typedef enum logic [1:0] {
        S_INIT       = 2'b00,
        S_INIT_FLUSH = 2'b01,
        S_IDLE       = 2'b10,
        S_RD         = 2'b11
    } state_t;

    function automatic counter_t sat_inc(input counter_t c);
        counter_t r;
        case (c)
            SNT:     r = WNT;
            WNT:     r = WT;
            WT:      r = ST;
            ST:      r = ST;
            default: r = ST;
        endcase
        return r;
    endfunction

    function automatic counter_t sat_dec(input counter_t c);
        counter_t r;
        case (c)
            SNT:     r = SNT;
            WNT:     r = SNT;
            WT:      r = WNT;
            ST:      r = WT;
            default: r = SNT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/predictor_index_hash.sv
// Gshare index hash: word-aligned PC bits XOR global history. Also meant for the BTB indexer.
module predictor_index_hash #(
    parameter int INDEX_WIDTH = 8,
    parameter int PC_WIDTH    = 32
) (
    input  logic [PC_WIDTH-1:0]    i_pc,
    input  logic [INDEX_WIDTH-1:0] i_ghr,
    output logic [INDEX_WIDTH-1:0] o_index
);

    // Byte-offset and high PC bits do not take part in the hash.
    logic w_unused_pc;
    assign w_unused_pc = ^{i_pc[PC_WIDTH-1:INDEX_WIDTH+2], i_pc[1:0]};

    assign o_index = i_pc[INDEX_WIDTH+1:2] ^ i_ghr;

endmodule

// File: rtl/predictor_table_ctrl.sv
// Gshare predictor controller: owns the dual-port counter SRAM, runs the init sweep,
// serves fetch predictions on port 0 and read-modify-write updates on port 1.
module predictor_table_ctrl
    import predictor_pkg::*;
#(
    parameter int       INDEX_WIDTH = 8,
    parameter int       PC_WIDTH    = 32,
    parameter counter_t INIT_STATE  = WNT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pred_req_valid,
    input  logic [PC_WIDTH-1:0]    pred_req_pc,
    output logic                   pred_req_ready,
    output logic                   pred_rsp_valid,
    output logic                   pred_rsp_taken,
    output logic [INDEX_WIDTH-1:0] pred_rsp_index,
    input  logic                   upd_valid,
    input  logic [INDEX_WIDTH-1:0] upd_index,
    input  logic                   upd_taken,
    output logic                   upd_ready,
    output logic                   init_done,
    output logic                   tbl_csb0,
    output logic                   tbl_web0,
    output logic [INDEX_WIDTH-1:0] tbl_addr0,
    input  logic [1:0]             tbl_dout0,
    output logic                   tbl_csb1,
    output logic                   tbl_web1,
    output logic [INDEX_WIDTH-1:0] tbl_addr1,
    output logic [1:0]             tbl_din1,
    input  logic [1:0]             tbl_dout1
);

    localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [INDEX_WIDTH-1:0] IDX_LAST = {INDEX_WIDTH{1'b1}};

    state_t                 r_state, w_state_nxt;
    logic [INDEX_WIDTH-1:0] r_sweep, w_sweep_nxt;
    logic [INDEX_WIDTH-1:0] r_ghr, w_ghr_nxt;
    logic [INDEX_WIDTH-1:0] r_upd_idx;
    logic                   r_upd_taken;
    logic                   r_init_done;
    logic                   r_rsp_valid;
    logic [INDEX_WIDTH-1:0] r_rsp_idx;
    logic                   r_byp_hit;
    logic                   r_byp_taken;
    logic [INDEX_WIDTH-1:0] w_idx;
    logic                   w_pred_acc;
    logic                   w_upd_acc;
    counter_t               w_new_ctr;
    logic                   w_unused_dout0;

    predictor_index_hash #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .PC_WIDTH    (PC_WIDTH)
    ) u_hash (
        .i_pc    (pred_req_pc),
        .i_ghr   (r_ghr),
        .o_index (w_idx)
    );

    assign w_pred_acc = pred_req_valid & r_init_done;
    assign w_upd_acc  = upd_valid & upd_ready;
    assign w_new_ctr  = r_upd_taken ? sat_inc(tbl_dout1) : sat_dec(tbl_dout1);

    // Port 0: read-only prediction port, addressed in the accept cycle.
    always_comb begin
        tbl_csb0  = 1'b1;
        tbl_web0  = 1'b1;
        tbl_addr0 = '0;
        if (w_pred_acc) begin
            tbl_csb0  = 1'b0;
            tbl_addr0 = w_idx;
        end else begin
            tbl_csb0  = 1'b1;
        end
    end

    // Port 1 FSM: init sweep, then read (IDLE) / write-back (RD) counter updates.
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        w_ghr_nxt   = r_ghr;
        upd_ready   = 1'b0;
        tbl_csb1    = 1'b1;
        tbl_web1    = 1'b1;
        tbl_addr1   = '0;
        tbl_din1    = SNT;
        // Held in reset, the SRAM must see a deselected port even though the state reads INIT.
        if (!rst_n) begin
            w_state_nxt = S_INIT;
        end else begin
            case (r_state)
                S_INIT: begin
                    tbl_csb1  = 1'b0;
                    tbl_web1  = 1'b0;
                    tbl_addr1 = r_sweep;
                    tbl_din1  = INIT_STATE;
                    if (r_sweep == IDX_LAST) begin
                        w_state_nxt = S_INIT_FLUSH;
                    end else begin
                        w_sweep_nxt = r_sweep + IDX_ONE;
                    end
                end
                S_INIT_FLUSH: begin
                    w_state_nxt = S_IDLE;
                end
                S_IDLE: begin
                    upd_ready = 1'b1;
                    if (upd_valid) begin
                        tbl_csb1    = 1'b0;
                        tbl_addr1   = upd_index;
                        w_ghr_nxt   = {r_ghr[INDEX_WIDTH-2:0], upd_taken};
                        w_state_nxt = S_RD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_RD: begin
                    tbl_csb1    = 1'b0;
                    tbl_web1    = 1'b0;
                    tbl_addr1   = r_upd_idx;
                    tbl_din1    = w_new_ctr;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_INIT;
                end
            endcase
        end
    end

    // Controller state: FSM, sweep pointer, history and the held update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_sweep     <= '0;
            r_ghr       <= '0;
            r_upd_idx   <= '0;
            r_upd_taken <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sweep <= w_sweep_nxt;
            r_ghr   <= w_ghr_nxt;
            if (w_upd_acc) begin
                r_upd_idx   <= upd_index;
                r_upd_taken <= upd_taken;
            end
            if (r_state == S_INIT_FLUSH) begin
                r_init_done <= 1'b1;
            end
        end
    end

    // Prediction response pipe; a read issued during RD to the written index is stale, so forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_idx   <= '0;
            r_byp_hit   <= 1'b0;
            r_byp_taken <= 1'b0;
        end else begin
            r_rsp_valid <= w_pred_acc;
            if (w_pred_acc) begin
                r_rsp_idx <= w_idx;
            end
            r_byp_hit   <= w_pred_acc && (r_state == S_RD) && (w_idx == r_upd_idx);
            r_byp_taken <= w_new_ctr[1];
        end
    end

    assign w_unused_dout0 = tbl_dout0[0];

    assign pred_req_ready = r_init_done;
    assign init_done      = r_init_done;
    assign pred_rsp_valid = r_rsp_valid;
    assign pred_rsp_index = r_rsp_idx;
    assign pred_rsp_taken = r_rsp_valid & (r_byp_hit ? r_byp_taken : tbl_dout0[1]);

endmodule

// File: tb/tb_predictor_table_ctrl.sv
// Directed self-checking bench for predictor_table_ctrl with a behavioural dual-port SRAM.
module tb_predictor_table_ctrl;

    localparam int IW    = 8;
    localparam int PW    = 32;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pred_req_valid = 1'b0;
    logic [PW-1:0] pred_req_pc = '0;
    logic          pred_req_ready;
    logic          pred_rsp_valid;
    logic          pred_rsp_taken;
    logic [IW-1:0] pred_rsp_index;
    logic          upd_valid = 1'b0;
    logic [IW-1:0] upd_index = '0;
    logic          upd_taken = 1'b0;
    logic          upd_ready;
    logic          init_done;
    logic          tbl_csb0, tbl_web0, tbl_csb1, tbl_web1;
    logic [IW-1:0] tbl_addr0, tbl_addr1;
    logic [1:0]    tbl_dout0, tbl_dout1, tbl_din1;

    int            checks = 0;
    int            errors = 0;
    logic [IW-1:0] ghr_m = '0;

    always #5 clk = ~clk;

    predictor_table_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pred_req_valid (pred_req_valid),
        .pred_req_pc    (pred_req_pc),
        .pred_req_ready (pred_req_ready),
        .pred_rsp_valid (pred_rsp_valid),
        .pred_rsp_taken (pred_rsp_taken),
        .pred_rsp_index (pred_rsp_index),
        .upd_valid      (upd_valid),
        .upd_index      (upd_index),
        .upd_taken      (upd_taken),
        .upd_ready      (upd_ready),
        .init_done      (init_done),
        .tbl_csb0       (tbl_csb0),
        .tbl_web0       (tbl_web0),
        .tbl_addr0      (tbl_addr0),
        .tbl_dout0      (tbl_dout0),
        .tbl_csb1       (tbl_csb1),
        .tbl_web1       (tbl_web1),
        .tbl_addr1      (tbl_addr1),
        .tbl_din1       (tbl_din1),
        .tbl_dout1      (tbl_dout1)
    );

    // SRAM model: address latched on the csb=0 edge, read data next cycle, write commits one edge later.
    logic [1:0]    mem [0:DEPTH-1];
    logic          wr_pend = 1'b0;
    logic [IW-1:0] wr_addr = '0;
    logic [1:0]    wr_data = 2'b00;

    always @(posedge clk) begin
        if (wr_pend) mem[wr_addr] <= wr_data;
        wr_pend <= !tbl_csb1 && !tbl_web1;
        wr_addr <= tbl_addr1;
        wr_data <= tbl_din1;
        if (!tbl_csb0) tbl_dout0 <= (wr_pend && wr_addr == tbl_addr0) ? wr_data : mem[tbl_addr0];
        if (!tbl_csb1 && tbl_web1) tbl_dout1 <= (wr_pend && wr_addr == tbl_addr1) ? wr_data : mem[tbl_addr1];
    end

    // Asserts reset at the current time, checks reset outputs, releases and checks the full sweep.
    task automatic reset_and_init(input string tag, input int watch);
        int cyc;
        int bad;
        rst_n = 1'b0;
        pred_req_valid = 1'b0;
        upd_valid = 1'b0;
        ghr_m = '0;
        #1;
        checks++;
        if ({pred_rsp_valid, pred_rsp_taken, upd_ready, pred_req_ready, init_done,
             tbl_csb0, tbl_web0, tbl_csb1, tbl_web1} !== 9'b0_0000_1111) begin
            errors++;
            $display("FAIL %s_reset_ctrl: got %b expected 000001111", tag,
                     {pred_rsp_valid, pred_rsp_taken, upd_ready, pred_req_ready, init_done,
                      tbl_csb0, tbl_web0, tbl_csb1, tbl_web1});
        end
        checks++;
        if ({tbl_addr0, tbl_addr1, tbl_din1} !== 18'h00000) begin
            errors++;
            $display("FAIL %s_reset_addr: got %h expected 00000", tag, {tbl_addr0, tbl_addr1, tbl_din1});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        if (watch >= 0) begin
            checks++;
            if (mem[watch] !== 2'b01) begin
                errors++;
                $display("FAIL %s_no_partial_write: entry %0d got %b expected 01", tag, watch, mem[watch]);
            end
        end
        checks++;
        if ({tbl_csb1, tbl_web1, tbl_addr1, tbl_din1} !== {1'b0, 1'b0, 8'h00, 2'b01}) begin
            errors++;
            $display("FAIL %s_sweep_start: got %b/%b/%h/%b expected 0/0/00/01", tag,
                     tbl_csb1, tbl_web1, tbl_addr1, tbl_din1);
        end
        cyc = 0;
        while (init_done !== 1'b1 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc != DEPTH + 1) begin
            errors++;
            $display("FAIL %s_init_latency: got %0d cycles expected %0d", tag, cyc, DEPTH + 1);
        end
        checks++;
        if ({pred_req_ready, upd_ready} !== 2'b11) begin
            errors++;
            $display("FAIL %s_ready_after_init: got %b expected 11", tag, {pred_req_ready, upd_ready});
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 2'b01) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_table_init: %0d entries differ, expected 0", tag, bad);
        end
        @(negedge clk);
    endtask

    // Waits (bounded) for upd_ready, issues one update, returns at the negedge of its RD cycle.
    task automatic do_update(input logic [IW-1:0] idx, input logic tk, output int waited);
        waited = 0;
        while (upd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (upd_ready !== 1'b1) begin
            errors++;
            $display("FAIL upd_ready_wait: got %b after %0d cycles expected 1", upd_ready, waited);
        end
        upd_valid = 1'b1;
        upd_index = idx;
        upd_taken = tk;
        ghr_m = {ghr_m[IW-2:0], tk};
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    // Issues one prediction whose hashed index is idx; returns the response fields.
    task automatic predict(input logic [IW-1:0] idx, output logic [IW+1:0] rsp);
        logic [IW-1:0] pcbits;
        pcbits = idx ^ ghr_m;
        pred_req_valid = 1'b1;
        pred_req_pc = {{(PW-IW-2){1'b0}}, pcbits, 2'b00};
        @(negedge clk);
        pred_req_valid = 1'b0;
        rsp = {pred_rsp_valid, pred_rsp_taken, pred_rsp_index};
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset_and_init("por", -1);
    endtask

    task automatic test_predict_sweep;
        logic [IW-1:0] e;
        for (int k = 0; k < DEPTH; k++) begin
            e = k[IW-1:0];
            pred_req_valid = 1'b1;
            pred_req_pc = {{(PW-IW-2){1'b0}}, e, 2'b00};
            @(negedge clk);
            checks++;
            if ({pred_rsp_valid, pred_rsp_taken, pred_rsp_index} !== {1'b1, 1'b0, e}) begin
                errors++;
                $display("FAIL sweep_predict: got v=%b t=%b idx=%h expected v=1 t=0 idx=%h",
                         pred_rsp_valid, pred_rsp_taken, pred_rsp_index, e);
            end
        end
        pred_req_valid = 1'b0;
    endtask

    task automatic test_saturate;
        logic [IW+1:0] rsp;
        logic [1:0]    inc_exp [0:2];
        logic [1:0]    dec_exp [0:3];
        int            w;
        inc_exp = '{2'b10, 2'b11, 2'b11};
        dec_exp = '{2'b10, 2'b01, 2'b00, 2'b00};
        predict(8'h10, rsp);
        checks++;
        if (rsp !== {1'b1, 1'b0, 8'h10} || pred_req_pc !== 32'h40) begin
            errors++;
            $display("FAIL sat_first_predict: got %b (pc %h) expected v=1 t=0 idx=10 pc=40", rsp, pred_req_pc);
        end
        for (int i = 0; i < 3; i++) begin
            do_update(8'h10, 1'b1, w);
            repeat (2) @(negedge clk);
            checks++;
            if (mem[8'h10] !== inc_exp[i]) begin
                errors++;
                $display("FAIL sat_inc_%0d: got %b expected %b", i, mem[8'h10], inc_exp[i]);
            end
        end
        predict(8'h10, rsp);
        checks++;
        if (rsp !== {1'b1, 1'b1, 8'h10}) begin
            errors++;
            $display("FAIL sat_taken_predict: got %b expected 1_1_00010000", rsp);
        end
        for (int i = 0; i < 4; i++) begin
            do_update(8'h10, 1'b0, w);
            repeat (2) @(negedge clk);
            checks++;
            if (mem[8'h10] !== dec_exp[i]) begin
                errors++;
                $display("FAIL sat_dec_%0d: got %b expected %b", i, mem[8'h10], dec_exp[i]);
            end
        end
        predict(8'h10, rsp);
        checks++;
        if (rsp !== {1'b1, 1'b0, 8'h10}) begin
            errors++;
            $display("FAIL sat_nt_predict: got %b expected 1_0_00010000", rsp);
        end
    endtask

    task automatic test_back_to_back;
        logic [IW+1:0] rsp;
        int            w;
        do_update(8'h05, 1'b1, w);
        checks++;
        if (upd_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rd_busy: upd_ready got %b expected 0", upd_ready);
        end
        do_update(8'h05, 1'b1, w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL b2b_accept: waited %0d cycles expected 1", w);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mem[8'h05] !== 2'b11) begin
            errors++;
            $display("FAIL b2b_counter: got %b expected 11", mem[8'h05]);
        end
        predict(8'h05, rsp);
        checks++;
        if (rsp !== {1'b1, 1'b1, 8'h05}) begin
            errors++;
            $display("FAIL b2b_predict: got %b expected 1_1_00000101", rsp);
        end
    endtask

    task automatic test_bypass;
        logic [IW+1:0] rsp;
        int            w;
        do_update(8'h07, 1'b1, w);
        predict(8'h07, rsp);
        checks++;
        if (rsp !== {1'b1, 1'b1, 8'h07}) begin
            errors++;
            $display("FAIL bypass_hit: got %b expected 1_1_00000111", rsp);
        end
        checks++;
        if (mem[8'h07] !== 2'b01) begin
            errors++;
            $display("FAIL bypass_stale_array: got %b expected 01", mem[8'h07]);
        end
        do_update(8'h07, 1'b1, w);
        predict(8'h08, rsp);
        checks++;
        if (rsp !== {1'b1, 1'b0, 8'h08}) begin
            errors++;
            $display("FAIL bypass_other_index: got %b expected 1_0_00001000", rsp);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mem[8'h07] !== 2'b11) begin
            errors++;
            $display("FAIL bypass_commit: got %b expected 11", mem[8'h07]);
        end
    endtask

    task automatic test_reset_rd;
        int n;
        n = 0;
        while (upd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        upd_valid = 1'b1;
        upd_index = 8'h30;
        upd_taken = 1'b1;
        pred_req_valid = 1'b1;
        pred_req_pc = '0;
        @(negedge clk);
        upd_valid = 1'b0;
        pred_req_valid = 1'b0;
        checks++;
        if ({pred_rsp_valid, tbl_csb1, tbl_web1, tbl_addr1} !== {1'b1, 1'b0, 1'b0, 8'h30}) begin
            errors++;
            $display("FAIL rd_setup: got %b expected 1_0_0_00110000",
                     {pred_rsp_valid, tbl_csb1, tbl_web1, tbl_addr1});
        end
        reset_and_init("rd", 8'h30);
    endtask

    task automatic test_reset_sweep;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if ({init_done, tbl_csb1, tbl_addr1} !== {1'b0, 1'b0, 8'd100}) begin
            errors++;
            $display("FAIL sweep_progress: got %b expected 0_0_01100100", {init_done, tbl_csb1, tbl_addr1});
        end
        reset_and_init("sweep", -1);
    endtask

    task automatic test_ghr;
        int w;
        do_update(8'h20, 1'b1, w);
        do_update(8'h20, 1'b0, w);
        do_update(8'h20, 1'b1, w);
        pred_req_valid = 1'b1;
        pred_req_pc = '0;
        @(negedge clk);
        pred_req_valid = 1'b0;
        checks++;
        if ({pred_rsp_valid, pred_rsp_taken, pred_rsp_index} !== {1'b1, 1'b0, 8'h05}) begin
            errors++;
            $display("FAIL ghr_index: got v=%b t=%b idx=%h expected v=1 t=0 idx=05",
                     pred_rsp_valid, pred_rsp_taken, pred_rsp_index);
        end
    endtask

    initial begin
        test_reset();
        test_predict_sweep();
        test_saturate();
        test_back_to_back();
        test_bypass();
        test_reset_rd();
        test_reset_sweep();
        test_ghr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
